// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with a bounded hold time per grant.
// Grant is registered: one cycle from sampled req to gnt; each release forces one idle cycle.
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       tmo
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [1:0] id_nxt;
  logic [7:0] hold_cnt, cnt_nxt;
  logic       tmo_nxt;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;
  logic       owner_req;
  logic       release_now;

  // First requester found scanning upward from the rotating pointer.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign owner_req   = req[gnt_id];
  assign release_now = !owner_req || !en || (hold_cnt == HOLD_LIM);

  always_comb begin
    state_nxt = state;
    id_nxt    = gnt_id;
    ptr_nxt   = ptr;
    cnt_nxt   = hold_cnt;
    tmo_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (en && found) begin
          state_nxt = GRANT;
          id_nxt    = winner;
          cnt_nxt   = 8'd1;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_nxt = IDLE;
          ptr_nxt   = gnt_id + 2'd1;
          cnt_nxt   = 8'd0;
          // Only a pure hold-limit expiry is flagged, not a drop or disable.
          tmo_nxt   = owner_req && en;
        end else begin
          cnt_nxt = hold_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      hold_cnt  <= 8'd0;
      gnt_id    <= 2'd0;
      gnt       <= 4'd0;
      gnt_valid <= 1'b0;
      tmo       <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= cnt_nxt;
      gnt_id    <= id_nxt;
      gnt       <= (state_nxt == GRANT) ? (4'b0001 << id_nxt) : 4'd0;
      gnt_valid <= (state_nxt == GRANT);
      tmo       <= tmo_nxt;
    end
  end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Round-robin arbiter that shares one resource among 4 requesters.
- Scans `req` from a rotating priority pointer, registers the winner as a 2-bit grant index, and decodes it into a one-hot `gnt` bus (1-to-4 decode gated by the grant-valid enable).
- Each grant is held until the owner drops its request, the hold limit expires, or the global enable falls.
- Sits in front of shared datapath resources (bus, memory port, decoder-selected slave) in the student design set.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one grant may stay asserted; legal range 1..255.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- en  input  1  arbiter enable; 0 blocks new grants and releases any current grant
- req  input  4  request lines, req[i] high = requester i wants the resource
- gnt  output  4  one-hot grant, registered; all-zero when no owner
- gnt_id  output  2  index of current owner, valid only when gnt_valid=1
- gnt_valid  output  1  high while a grant is active; always equals |gnt
- tmo  output  1  one-cycle pulse in the cycle after a grant is ended by hold-limit expiry

Behaviour:
- Reset (rst=1 at edge): clears gnt=0, gnt_id=0, gnt_valid=0, tmo=0, ptr=0, hold_cnt=0, state=IDLE. Reset overrides everything, including mid-grant; no grant survives reset.
- State IDLE:
  - If en=1 and req!=0 at edge N: winner = first i with req[i]=1, scanning ptr, ptr+1, ... mod 4.
  - After edge N: gnt=onehot(winner), gnt_id=winner, gnt_valid=1, hold_cnt=1, state=GRANT. Latency is 1 cycle from sampled req to gnt.
  - Otherwise stay in IDLE with gnt=0.
- State GRANT: release at an edge if any of the following holds:
  - req[gnt_id]=0, or
  - en=0, or
  - hold_cnt==MAX_HOLD.
- On release:
  - gnt=0, gnt_valid=0, state=IDLE, ptr=(gnt_id+1) mod 4 (2-bit wrap, 3→0).
  - tmo=1 for one cycle only if hold_cnt==MAX_HOLD and the other two conditions are false.
  - If no release condition holds, hold_cnt increments and gnt is unchanged.
- Hold length: gnt stays high for at most MAX_HOLD consecutive cycles. With MAX_HOLD=1, every grant lasts exactly one cycle.
- Turnaround: every release is followed by at least one IDLE cycle with gnt=0. No back-to-back grants, even to a different requester.
- Simultaneous events:
  - Release and new requests on the same edge: release wins. New arbitration happens from IDLE at the next edge using the updated ptr.
  - The timed-out requester keeping req high gets lowest priority. If it is the only requester, it is re-granted after the single idle cycle.
- Request changes in other requesters during GRANT are ignored. There is no preemption.
- en=0 in IDLE: no grant, ptr unchanged.
- Invariants, every cycle: gnt is one-hot or zero; gnt_valid==|gnt; gnt==onehot(gnt_id) when gnt_valid=1; tmo never high while gnt_valid=1.
- hold_cnt width is 8 bits. It never exceeds MAX_HOLD.

Test Plan:
1. Reset: rst=1 for 2 cycles with en=1, req=4'b1111. Required: gnt=0, gnt_valid=0, tmo=0 throughout. On the first edge after rst falls, gnt=4'b0001, gnt_id=0.
2. Single requester: en=1, req=4'b0100 for 3 cycles, then 0. Required: gnt=4'b0100, gnt_id=2 one cycle after req, held 3 cycles; gnt=0 the cycle after req drops; tmo=0.
3. Timeout, single requester: MAX_HOLD=8, req=4'b0010 held 20 cycles. Required:
   - gnt=4'b0010 in cycles 1-8, 0 in cycle 9 with tmo=1 in that cycle;
   - re-granted in cycles 10-17, 0 in cycle 18 with tmo=1.
4. Rotation: MAX_HOLD=4, req=4'b1111 held. Required: grant order 0,1,2,3,0, each grant 4 cycles, one idle cycle between grants, tmo pulsing in each idle cycle. Then with ptr=1, req=4'b1001 → next grant goes to 3.
5. Enable drop: grant active to requester 1, en falls mid-grant. Required:
   - gnt=0 next cycle, tmo=0, ptr=2;
   - no grant while en=0 despite req=4'b1111;
   - after en=1, first grant goes to 2.
6. Reset mid-grant plus MAX_HOLD=1: rst pulsed during a grant. Required: gnt=0 and ptr=0 after the edge. With MAX_HOLD=1 and req=4'b0011 held, the gnt pattern is 0001,0000,0010,0000,0001.
